// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int DEF_AW   = 10;
    localparam int DEF_DW   = 32;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Owner-tag delay line: remembers who issued each RAM read so the data
// returning DEPTH cycles later can be steered back to the right port.
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out
);

    owner_e stage_q [DEPTH];
    owner_e stage_d [DEPTH];

    always_comb begin
        stage_d[0] = owner_e'(tag_in);
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // A clear discards every in-flight tag so stale RAM data is never delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and
// data ports: data wins by default, a starvation counter bounds fetch waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
)
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic [1:0]          tag_push;
    logic [1:0]          tag_head;
    owner_e              head_own;

    // Fetch only beats a competing data request once it has lost STARVE_MAX times in a row.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!RST) begin
            if (if_req && d_req) begin
                if (starve_cnt_q == STARVE_LIM) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (if_req && !if_gnt) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        tag_push = OWN_NONE;
        if (if_gnt) begin
            tag_push = OWN_IF;
        end else if (d_gnt && !d_we) begin
            tag_push = OWN_D;
        end
    end

    mem_arb_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk     (CLK),
        .rst     (RST),
        .tag_in  (tag_push),
        .tag_out (tag_head)
    );

    assign head_own = owner_e'(tag_head);

    // Response steering is masked during reset so a tag caught at the head never escapes.
    always_comb begin
        if_rvalid = !RST && (head_own == OWN_IF);
        d_rvalid  = !RST && (head_own == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

endmodule
